// File: rtl/coeff_update_pkg.sv
// Shared types and helpers for the multi-lane coefficient update stage.
package coeff_update_pkg;

    typedef enum logic {
        POL_REJECT = 1'b0,
        POL_CLAMP  = 1'b1
    } bound_policy_e;

    localparam int DEF_COEFF_W = 16;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/coeff_lane_adj.sv
// One combinational lane: apply a signed adjustment against shared bounds,
// then saturate to the representable coefficient range.
module coeff_lane_adj
    import coeff_update_pkg::*;
#(
    parameter int COEFF_W = 16,
    parameter int CHG_W   = 2
) (
    input  logic [COEFF_W-1:0] coef,
    input  logic [CHG_W-1:0]   change,
    input  logic [COEFF_W:0]   bound_lo,
    input  logic [COEFF_W:0]   bound_hi,
    input  logic               clamp,
    output logic [COEFF_W-1:0] out_coef,
    output logic               hit,
    output logic               adj
);
    localparam int EXT_W = COEFF_W + 2;
    localparam logic signed [EXT_W-1:0] REP_MAX = {3'b000, {(COEFF_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] REP_MIN = {3'b111, {(COEFF_W-1){1'b0}}};

    logic signed [EXT_W-1:0] ext_s, d_s, p_s, lo_s, hi_s, sel_s;
    logic                    sel_hit_s;
    bound_policy_e           pol_s;

    assign ext_s = {{2{coef[COEFF_W-1]}}, coef};
    assign d_s   = {{(EXT_W-CHG_W){change[CHG_W-1]}}, change};
    assign lo_s  = {bound_lo[COEFF_W], bound_lo};
    assign hi_s  = {bound_hi[COEFF_W], bound_hi};
    assign p_s   = ext_s + d_s;
    assign pol_s = clamp ? POL_CLAMP : POL_REJECT;

    // Bound policy: inverted bounds always reject, otherwise reject or clamp
    always_comb begin
        sel_s     = ext_s;
        sel_hit_s = 1'b0;
        if (change == {CHG_W{1'b0}}) begin
            sel_s     = ext_s;
            sel_hit_s = 1'b0;
        end else if (lo_s > hi_s) begin
            sel_s     = ext_s;
            sel_hit_s = 1'b1;
        end else if (p_s > hi_s) begin
            sel_hit_s = 1'b1;
            sel_s     = (pol_s == POL_CLAMP) ? hi_s : ext_s;
        end else if (p_s < lo_s) begin
            sel_hit_s = 1'b1;
            sel_s     = (pol_s == POL_CLAMP) ? lo_s : ext_s;
        end else begin
            sel_s     = p_s;
            sel_hit_s = 1'b0;
        end
    end

    // Representability saturation; a saturated lane is always reported as a hit
    always_comb begin
        out_coef = sel_s[COEFF_W-1:0];
        hit      = sel_hit_s;
        if (sel_s > REP_MAX) begin
            out_coef = REP_MAX[COEFF_W-1:0];
            hit      = 1'b1;
        end else if (sel_s < REP_MIN) begin
            out_coef = REP_MIN[COEFF_W-1:0];
            hit      = 1'b1;
        end else begin
            out_coef = sel_s[COEFF_W-1:0];
            hit      = sel_hit_s;
        end
    end

    assign adj = (out_coef != coef);

endmodule

// File: rtl/coeff_update_mc.sv
// Two-stage multi-lane coefficient update with ready/valid backpressure
// and a saturating bound-hit counter.
module coeff_update_mc
    import coeff_update_pkg::*;
#(
    parameter int COEFF_W = DEF_COEFF_W,
    parameter int LANES   = 4,
    parameter int CHG_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [LANES*COEFF_W-1:0] s_coef,
    input  logic [LANES*CHG_W-1:0]   s_change,
    input  logic [COEFF_W:0]         s_min,
    input  logic [COEFF_W:0]         s_max,
    input  logic                     s_last,
    input  logic                     cfg_clamp,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [LANES*COEFF_W-1:0] m_coef,
    output logic [LANES-1:0]         m_adj_mask,
    output logic [LANES-1:0]         m_hit_mask,
    output logic                     m_last,
    input  logic                     stat_clr,
    output logic [CNT_W-1:0]         stat_hits
);
    localparam int SUM_W = CNT_W + 6;
    localparam logic [SUM_W-1:0] CNT_MAX = {6'd0, {CNT_W{1'b1}}};

    logic                     en_s;
    logic                     v1_q, v1_d, last1_q, last1_d, clamp1_q, clamp1_d;
    logic [LANES*COEFF_W-1:0] coef1_q, coef1_d;
    logic [LANES*CHG_W-1:0]   chg1_q, chg1_d;
    logic [COEFF_W:0]         min1_q, min1_d, max1_q, max1_d;
    logic                     v2_q, v2_d, last2_q, last2_d;
    logic [LANES*COEFF_W-1:0] coef2_q, coef2_d, lane_coef_s;
    logic [LANES-1:0]         adj2_q, adj2_d, hit2_q, hit2_d, lane_adj_s, lane_hit_s;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SUM_W-1:0]         sum_s;

    assign en_s = !v2_q || m_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        coeff_lane_adj #(.COEFF_W(COEFF_W), .CHG_W(CHG_W)) u_lane (
            .coef     (coef1_q[g*COEFF_W +: COEFF_W]),
            .change   (chg1_q[g*CHG_W +: CHG_W]),
            .bound_lo (min1_q),
            .bound_hi (max1_q),
            .clamp    (clamp1_q),
            .out_coef (lane_coef_s[g*COEFF_W +: COEFF_W]),
            .hit      (lane_hit_s[g]),
            .adj      (lane_adj_s[g])
        );
    end

    // Stage 1: capture the accepted input beat; bubbles keep the old data
    always_comb begin
        v1_d     = v1_q;
        coef1_d  = coef1_q;
        chg1_d   = chg1_q;
        min1_d   = min1_q;
        max1_d   = max1_q;
        last1_d  = last1_q;
        clamp1_d = clamp1_q;
        if (en_s) begin
            v1_d = s_valid;
            if (s_valid) begin
                coef1_d  = s_coef;
                chg1_d   = s_change;
                min1_d   = s_min;
                max1_d   = s_max;
                last1_d  = s_last;
                clamp1_d = cfg_clamp;
            end else begin
                coef1_d = coef1_q;
            end
        end else begin
            v1_d = v1_q;
        end
    end

    // Stage 2: register the lane results that drive the outputs
    always_comb begin
        v2_d    = v2_q;
        coef2_d = coef2_q;
        adj2_d  = adj2_q;
        hit2_d  = hit2_q;
        last2_d = last2_q;
        if (en_s) begin
            v2_d = v1_q;
            if (v1_q) begin
                coef2_d = lane_coef_s;
                adj2_d  = lane_adj_s;
                hit2_d  = lane_hit_s;
                last2_d = last1_q;
            end else begin
                coef2_d = coef2_q;
            end
        end else begin
            v2_d = v2_q;
        end
    end

    // Hit counter: clear wins over the beat transferring in the same cycle
    always_comb begin
        sum_s = SUM_W'(cnt_q) + SUM_W'(popcount32(32'(hit2_q)));
        cnt_d = cnt_q;
        if (stat_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (v2_q && m_ready) begin
            cnt_d = (sum_s > CNT_MAX) ? {CNT_W{1'b1}} : sum_s[CNT_W-1:0];
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pipeline and counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            coef1_q  <= '0;
            chg1_q   <= '0;
            min1_q   <= '0;
            max1_q   <= '0;
            last1_q  <= 1'b0;
            clamp1_q <= 1'b0;
            v2_q     <= 1'b0;
            coef2_q  <= '0;
            adj2_q   <= '0;
            hit2_q   <= '0;
            last2_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            v1_q     <= v1_d;
            coef1_q  <= coef1_d;
            chg1_q   <= chg1_d;
            min1_q   <= min1_d;
            max1_q   <= max1_d;
            last1_q  <= last1_d;
            clamp1_q <= clamp1_d;
            v2_q     <= v2_d;
            coef2_q  <= coef2_d;
            adj2_q   <= adj2_d;
            hit2_q   <= hit2_d;
            last2_q  <= last2_d;
            cnt_q    <= cnt_d;
        end
    end

    assign s_ready    = en_s;
    assign m_valid    = v2_q;
    assign m_coef     = coef2_q;
    assign m_adj_mask = adj2_q;
    assign m_hit_mask = hit2_q;
    assign m_last     = last2_q;
    assign stat_hits  = cnt_q;

endmodule

// File: tb/tb_coeff_update_mc.sv
// Self-checking bench: directed table, counter/backpressure/reset sequences,
// and random traffic against an integer reference model with a scoreboard.
module tb_coeff_update_mc;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_valid, s_ready, s_last, cfg_clamp, m_valid, m_ready, m_last, stat_clr;
    logic [63:0] s_coef, m_coef;
    logic [7:0]  s_change;
    logic [16:0] s_min, s_max;
    logic [3:0]  m_adj_mask, m_hit_mask;
    logic [15:0] stat_hits;

    logic        s_valid2, s_ready2, s_last2, cfg_clamp2, m_valid2, m_ready2, m_last2, stat_clr2;
    logic [63:0] s_coef2, m_coef2;
    logic [11:0] s_change2;
    logic [16:0] s_min2, s_max2;
    logic [3:0]  m_adj_mask2, m_hit_mask2;
    logic [2:0]  stat_hits2;

    coeff_update_mc dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_coef(s_coef),
        .s_change(s_change), .s_min(s_min), .s_max(s_max), .s_last(s_last),
        .cfg_clamp(cfg_clamp), .m_valid(m_valid), .m_ready(m_ready), .m_coef(m_coef),
        .m_adj_mask(m_adj_mask), .m_hit_mask(m_hit_mask), .m_last(m_last),
        .stat_clr(stat_clr), .stat_hits(stat_hits)
    );

    coeff_update_mc #(.COEFF_W(16), .LANES(4), .CHG_W(3), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .s_valid(s_valid2), .s_ready(s_ready2), .s_coef(s_coef2),
        .s_change(s_change2), .s_min(s_min2), .s_max(s_max2), .s_last(s_last2),
        .cfg_clamp(cfg_clamp2), .m_valid(m_valid2), .m_ready(m_ready2), .m_coef(m_coef2),
        .m_adj_mask(m_adj_mask2), .m_hit_mask(m_hit_mask2), .m_last(m_last2),
        .stat_clr(stat_clr2), .stat_hits(stat_hits2)
    );

    typedef struct {
        logic [63:0] coef;
        logic [3:0]  adj;
        logic [3:0]  hit;
        logic        last;
    } exp_t;

    typedef struct {
        int         c[4];
        int         ch[4];
        int         mn;
        int         mx;
        bit         clamp;
        int         ec[4];
        logic [3:0] adj;
        logic [3:0] hit;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   in_c[4], in_ch[4], in_mn, in_mx;
    bit   in_clamp, in_last, in_valid, in_ready, in_clr;
    exp_t exp_q[$];
    int   cnt_m = 0;
    int   n_acc = 0;
    bit   stall_prev = 1'b0;
    logic [63:0] prev_coef = 64'd0;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input int a[4]);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'(a[i]);
        return r;
    endfunction

    // Reference: plain integer arithmetic straight from the lane rules
    function automatic exp_t model(input int c[4], input int ch[4], input int mn, input int mx,
                                   input bit clamp, input bit last);
        exp_t e;
        int   o;
        bit   h;
        e.coef = 64'd0; e.adj = 4'd0; e.hit = 4'd0; e.last = last;
        for (int i = 0; i < 4; i++) begin
            o = c[i];
            h = 1'b0;
            if (ch[i] != 0) begin
                if (mn > mx) h = 1'b1;
                else if (c[i] + ch[i] > mx) begin h = 1'b1; if (clamp) o = mx; end
                else if (c[i] + ch[i] < mn) begin h = 1'b1; if (clamp) o = mn; end
                else o = c[i] + ch[i];
            end
            if (o > 32767) begin o = 32767; h = 1'b1; end
            if (o < -32768) begin o = -32768; h = 1'b1; end
            e.coef[i*16 +: 16] = 16'(o);
            e.hit[i] = h;
            e.adj[i] = (o != c[i]);
        end
        return e;
    endfunction

    task automatic set_row(input int r);
        in_c = tbl[r].c; in_ch = tbl[r].ch; in_mn = tbl[r].mn; in_mx = tbl[r].mx;
        in_clamp = tbl[r].clamp; in_last = r[0];
    endtask

    // One clock: drive, check handshake/scoreboard before the edge, then advance
    task automatic step();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            s_coef[i*16 +: 16] = 16'(in_c[i]);
            s_change[i*2 +: 2] = 2'(in_ch[i]);
        end
        s_min = 17'(in_mn); s_max = 17'(in_mx); cfg_clamp = in_clamp; s_last = in_last;
        s_valid = in_valid; m_ready = in_ready; stat_clr = in_clr;
        #1;
        chk("s_ready", 64'(s_ready), 64'(!(m_valid && !in_ready)));
        chk("stat_hits", 64'(stat_hits), 64'(cnt_m));
        if (stall_prev) begin
            chk("stall_valid", 64'(m_valid), 64'(1'b1));
            chk("stall_coef", m_coef, prev_coef);
        end
        if (m_valid && in_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 64'(m_valid), 64'(1'b0));
            end else begin
                e = exp_q.pop_front();
                chk("m_coef", m_coef, e.coef);
                chk("m_adj_mask", 64'(m_adj_mask), 64'(e.adj));
                chk("m_hit_mask", 64'(m_hit_mask), 64'(e.hit));
                chk("m_last", 64'(m_last), 64'(e.last));
                cnt_m = cnt_m + $countones(e.hit);
                if (cnt_m > 65535) cnt_m = 65535;
            end
        end
        if (in_clr) cnt_m = 0;
        if (in_valid && s_ready) begin
            exp_q.push_back(model(in_c, in_ch, in_mn, in_mx, in_clamp, in_last));
            n_acc++;
        end
        stall_prev = m_valid && !in_ready;
        prev_coef = m_coef;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{'{5, -5, 0, 99}, '{1, -1, 0, 1}, -100, 100, 1'b0, '{6, -6, 0, 100}, 4'b1011, 4'b0000};
        tbl[1] = '{'{100, 100, -100, -100}, '{1, 1, -1, -2}, -100, 100, 1'b0, '{100, 100, -100, -100}, 4'b0000, 4'b1111};
        tbl[2] = '{'{100, 99, -100, -99}, '{1, 1, -2, -2}, -100, 100, 1'b1, '{100, 100, -100, -100}, 4'b1010, 4'b1101};
        tbl[3] = '{'{32767, -32768, 32767, 0}, '{1, -1, -1, 1}, -40000, 40000, 1'b0, '{32767, -32768, 32766, 1}, 4'b1100, 4'b0011};
        tbl[4] = '{'{7, 7, 7, 7}, '{-1, 0, 1, -2}, 10, 5, 1'b1, '{7, 7, 7, 7}, 4'b0000, 4'b1101};
        tbl[5] = '{'{0, 5, -5, 3}, '{-2, 1, -1, 1}, -5, 5, 1'b1, '{-2, 5, -5, 4}, 4'b1001, 4'b0110};
        tbl[6] = '{'{32767, -50, 10, 1}, '{1, 1, 1, -1}, 0, 40000, 1'b1, '{32767, 0, 11, 0}, 4'b1110, 4'b0011};
        tbl[7] = '{'{100, 0, 0, 0}, '{1, 0, 0, 0}, -100, 100, 1'b0, '{100, 0, 0, 0}, 4'b0000, 4'b0001};

        rst = 1'b1;
        in_c = '{0, 0, 0, 0}; in_ch = '{0, 0, 0, 0}; in_mn = 0; in_mx = 0;
        in_clamp = 1'b0; in_last = 1'b0; in_valid = 1'b0; in_ready = 1'b1; in_clr = 1'b0;
        s_valid = 1'b0; m_ready = 1'b1; stat_clr = 1'b0; s_coef = 64'd0; s_change = 8'd0;
        s_min = 17'd0; s_max = 17'd0; s_last = 1'b0; cfg_clamp = 1'b0;
        s_valid2 = 1'b0; m_ready2 = 1'b1; stat_clr2 = 1'b0; s_coef2 = {4{16'd99}};
        s_change2 = {4{3'b011}}; s_min2 = 17'(-100); s_max2 = 17'(100); s_last2 = 1'b0;
        cfg_clamp2 = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_m_valid", 64'(m_valid), 64'(1'b0));
        chk("rst_m_coef", m_coef, 64'd0);
        chk("rst_masks", 64'({m_adj_mask, m_hit_mask, m_last}), 64'd0);
        chk("rst_stat_hits", 64'(stat_hits), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Wider-change / narrow-counter instance: clamp to 100 and saturate at 7
        s_valid2 = 1'b1;
        step(); step();
        s_valid2 = 1'b0;
        chk("i2_m_valid", 64'(m_valid2), 64'(1'b1));
        chk("i2_m_coef", m_coef2, {4{16'd100}});
        chk("i2_masks", 64'({m_adj_mask2, m_hit_mask2}), 64'(8'hff));
        chk("i2_misc", 64'({s_ready2, m_last2}), 64'(2'b10));
        step();
        chk("i2_hits_4", 64'(stat_hits2), 64'd4);
        step();
        chk("i2_hits_sat", 64'(stat_hits2), 64'd7);

        // Directed table: each beat isolated so its 2-cycle latency is visible
        for (int r = 0; r < 8; r++) begin
            set_row(r);
            in_valid = 1'b1; in_ready = 1'b1;
            step();
            in_valid = 1'b0;
            chk("lat_not_early", 64'(m_valid), 64'(1'b0));
            step();
            chk("lat_valid", 64'(m_valid), 64'(1'b1));
            chk("tbl_coef", m_coef, pack4(tbl[r].ec));
            chk("tbl_adj", 64'(m_adj_mask), 64'(tbl[r].adj));
            chk("tbl_hit", 64'(m_hit_mask), 64'(tbl[r].hit));
        end
        step();

        // Counter: popcounts 2,4,1 then clear coinciding with a popcount-3 beat
        in_clr = 1'b1;
        step();
        in_clr = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                set_row((k == 0) ? 3 : (k == 1) ? 1 : (k == 2) ? 7 : 2);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            in_clr = (k == 5);
            if (k == 5) chk("hits_before_clr", 64'(stat_hits), 64'd7);
            step();
        end
        in_clr = 1'b0;
        chk("hits_after_clr", 64'(stat_hits), 64'd0);

        // Backpressure: beats 1..8 with m_ready pattern 1,0,0,1
        n_acc = 0;
        in_ch = '{0, 0, 0, 0}; in_mn = -100; in_mx = 100;
        for (int k = 0; k < 100; k++) begin
            if (n_acc >= 8 && exp_q.size() == 0) break;
            in_valid = (n_acc < 8);
            in_c = '{n_acc + 1, n_acc + 1, n_acc + 1, n_acc + 1};
            in_ready = (k % 4 == 0) || (k % 4 == 3);
            step();
        end
        chk("bp_accepted", 64'(n_acc), 64'd8);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Random traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0)
                    in_c[i] = ($urandom_range(0, 1) == 0) ? 32767 : -32768;
                else
                    in_c[i] = int'($urandom_range(0, 420)) - 210;
                in_ch[i] = int'($urandom_range(0, 3)) - 2;
            end
            in_mn = int'($urandom_range(0, 400)) - 220;
            in_mx = int'($urandom_range(0, 400)) - 180;
            if ($urandom_range(0, 9) == 0) in_mx = 40000;
            if ($urandom_range(0, 9) == 0) in_mn = -40000;
            in_clamp = 1'($urandom_range(0, 1));
            in_last  = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            in_ready = ($urandom_range(0, 3) != 0);
            in_clr   = ($urandom_range(0, 49) == 0);
            step();
        end
        in_clr = 1'b0;

        // Async reset while a stalled beat is held at the output
        set_row(1);
        in_valid = 1'b1; in_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step(); step();
        chk("pre_rst_valid", 64'(m_valid), 64'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_m_valid", 64'(m_valid), 64'(1'b0));
        chk("arst_stat_hits", 64'(stat_hits), 64'd0);
        chk("arst_masks", 64'({m_adj_mask, m_hit_mask, m_last}), 64'd0);
        chk("arst_m_coef", m_coef, 64'd0);
        exp_q.delete();
        cnt_m = 0;
        stall_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        set_row(5);
        in_valid = 1'b1; in_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("post_rst_not_early", 64'(m_valid), 64'(1'b0));
        step();
        chk("post_rst_valid", 64'(m_valid), 64'(1'b1));
        chk("post_rst_coef", m_coef, pack4(tbl[5].ec));
        step();
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
